// File: rtl/clock_digit_gen.sv
// 12-hour time-of-day keeper with a button-driven set mode and a blinking selected field.
// Emits one registered 4-bit display code per 7-segment digit, plus an AM/PM code.
module clock_digit_gen #(
   parameter int unsigned TICKS_PER_SEC = 50000000,
   parameter int unsigned BLINK_TICKS   = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       set_mode,
   input  logic       inc_hour,
   input  logic       inc_min,
   output logic [3:0] hr_tens,
   output logic [3:0] hr_ones,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] ampm,
   output logic       sec_tick
);

   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
   localparam logic [3:0] CODE_BLANK = 4'b1111;
   localparam logic [3:0] CODE_ONE   = 4'b0001;
   localparam logic [3:0] CODE_A     = 4'b1010;
   localparam logic [3:0] CODE_P     = 4'b1011;

   typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] presc;
   logic [BW-1:0] blink_cnt;
   logic          blink;
   logic [3:0]    hour, min_t, min_o, sec_t, sec_o;
   logic          pm;

   logic       run_c, terminal_c, hour_inc_c, min_inc_c;
   logic       sec_wrap_c, min_step_c, hour_step_c;
   logic [3:0] hour_nxt_c;
   logic       pm_nxt_c;
   logic [3:0] hr_tens_c, hr_ones_c, min_tens_c, min_ones_c, ampm_c;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (set_mode) begin
         case (state)
            RUN:      state_nxt = SET_HOUR;
            SET_HOUR: state_nxt = SET_MIN;
            default:  state_nxt = RUN;
         endcase
      end
   end

   // Control strobes and display decode; set_mode always pre-empts an edit or a tick.
   always_comb begin
      run_c       = (state == RUN);
      terminal_c  = run_c && !set_mode && (presc == PRESC_LAST);
      hour_inc_c  = (state == SET_HOUR) && inc_hour && !set_mode;
      min_inc_c   = (state == SET_MIN) && inc_min && !set_mode;
      sec_wrap_c  = terminal_c && (sec_t == 4'd5) && (sec_o == 4'd9);
      min_step_c  = sec_wrap_c || min_inc_c;
      hour_step_c = (sec_wrap_c && (min_t == 4'd5) && (min_o == 4'd9)) || hour_inc_c;

      hr_tens_c  = (hour >= 4'd10) ? CODE_ONE : CODE_BLANK;
      hr_ones_c  = (hour >= 4'd10) ? hour - 4'd10 : hour;
      min_tens_c = min_t;
      min_ones_c = min_o;
      ampm_c     = pm ? CODE_P : CODE_A;
      if (blink && state == SET_HOUR) begin
         hr_tens_c = CODE_BLANK;
         hr_ones_c = CODE_BLANK;
      end
      if (blink && state == SET_MIN) begin
         min_tens_c = CODE_BLANK;
         min_ones_c = CODE_BLANK;
      end
   end

   // Hour successor shared by the run carry and the set edit.
   always_comb begin
      hour_nxt_c = (hour == 4'd12) ? 4'd1 : hour + 4'd1;
      pm_nxt_c   = (hour == 4'd11) ? !pm : pm;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc <= '0;
         sec_t <= '0;
         sec_o <= '0;
         min_t <= '0;
         min_o <= '0;
         hour  <= 4'd12;
         pm    <= 1'b0;
      end else begin
         presc <= (run_c && !set_mode && !terminal_c) ? presc + PW'(1) : '0;
         if (run_c && set_mode) begin
            sec_t <= '0;
            sec_o <= '0;
         end else if (terminal_c) begin
            if (sec_o != 4'd9) sec_o <= sec_o + 4'd1;
            else begin
               sec_o <= '0;
               sec_t <= (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
            end
         end
         if (min_step_c) begin
            if (min_o != 4'd9) min_o <= min_o + 4'd1;
            else begin
               min_o <= '0;
               min_t <= (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
            end
         end
         if (hour_step_c) begin
            hour <= hour_nxt_c;
            pm   <= pm_nxt_c;
         end
      end
   end

   // Blink phase restarts visible on any set-state entry/exit or accepted edit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (run_c || set_mode || hour_inc_c || min_inc_c) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         blink     <= !blink;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hr_tens  <= CODE_ONE;
         hr_ones  <= 4'd2;
         min_tens <= 4'd0;
         min_ones <= 4'd0;
         ampm     <= CODE_A;
         sec_tick <= 1'b0;
      end else begin
         hr_tens  <= hr_tens_c;
         hr_ones  <= hr_ones_c;
         min_tens <= min_tens_c;
         min_ones <= min_ones_c;
         ampm     <= ampm_c;
         sec_tick <= terminal_c;
      end
   end

endmodule
